// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port data memory arbiter.
// FSM encodings and the default data width.
package mem_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and data_memory signals of the arbiter.
// slave is the arbiter side, master is the environment side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = DATA_WIDTH
);

    logic              i_req0_valid;
    logic              i_req1_valid;
    logic              o_req0_ready;
    logic              o_req1_ready;
    logic              i_req0_we;
    logic              i_req1_we;
    logic [ADDR_W-1:0] i_req0_addr;
    logic [ADDR_W-1:0] i_req1_addr;
    logic [DATA_W-1:0] i_req0_wdata;
    logic [DATA_W-1:0] i_req1_wdata;

    logic              o_rsp0_valid;
    logic              o_rsp1_valid;
    logic              i_rsp0_ready;
    logic              i_rsp1_ready;
    logic [DATA_W-1:0] o_rsp0_rdata;
    logic [DATA_W-1:0] o_rsp1_rdata;

    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_busy;

    modport slave (
        input  i_req0_valid, i_req1_valid,
        input  i_req0_we, i_req1_we,
        input  i_req0_addr, i_req1_addr,
        input  i_req0_wdata, i_req1_wdata,
        output o_req0_ready, o_req1_ready,
        output o_rsp0_valid, o_rsp1_valid,
        input  i_rsp0_ready, i_rsp1_ready,
        output o_rsp0_rdata, o_rsp1_rdata,
        output o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_busy
    );

    modport master (
        output i_req0_valid, i_req1_valid,
        output i_req0_we, i_req1_we,
        output i_req0_addr, i_req1_addr,
        output i_req0_wdata, i_req1_wdata,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp0_valid, o_rsp1_valid,
        output i_rsp0_ready, i_rsp1_ready,
        input  o_rsp0_rdata, o_rsp1_rdata,
        input  o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_busy
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// ptr picks the winner only when both requesters contend.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req0 & req1):  gnt = ptr ? 2'b10 : 2'b01;
            (req0 & ~req1): gnt = 2'b01;
            (~req0 & req1): gnt = 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port data_memory.
// One transaction in flight: IDLE -> ACCESS -> RESP.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = $clog2(MEM_SIZE),
    parameter int DATA_W   = DATA_WIDTH
) (
    input logic          i_clk,
    input logic          i_rst,
    mem_arbiter_if.slave bus
);

    logic [1:0]        state;
    logic              ptr;
    logic              gid;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        gnt;
    logic              idle;
    logic              resp;
    logic              rsp_hs;

    rr_arb2 u_arb (
        .req0 (bus.i_req0_valid),
        .req1 (bus.i_req1_valid),
        .ptr  (ptr),
        .gnt  (gnt)
    );

    // Hold off grants during reset so no handshake is silently lost.
    assign idle   = (state == ST_IDLE) && !i_rst;
    assign resp   = (state == ST_RESP);
    assign rsp_hs = resp && (gid ? bus.i_rsp1_ready : bus.i_rsp0_ready);

    assign bus.o_req0_ready = idle && gnt[0];
    assign bus.o_req1_ready = idle && gnt[1];

    assign bus.o_rsp0_valid = resp && !gid;
    assign bus.o_rsp1_valid = resp && gid;
    assign bus.o_rsp0_rdata = !gid ? rdata : '0;
    assign bus.o_rsp1_rdata = gid  ? rdata : '0;

    // Store enable masked by reset so an aborted ACCESS writes nothing.
    assign bus.o_mem_we    = (state == ST_ACCESS) && l_we && !i_rst;
    assign bus.o_mem_addr  = l_addr;
    assign bus.o_mem_wdata = l_wdata;
    assign bus.o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            gid     <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        gid     <= 1'b1;
                        l_we    <= bus.i_req1_we;
                        l_addr  <= bus.i_req1_addr;
                        l_wdata <= bus.i_req1_wdata;
                        state   <= ST_ACCESS;
                    end else if (gnt[0]) begin
                        gid     <= 1'b0;
                        l_we    <= bus.i_req0_we;
                        l_addr  <= bus.i_req0_addr;
                        l_wdata <= bus.i_req0_wdata;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata <= bus.i_mem_rdata;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        ptr   <= ~gid;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural data_memory.
// Memory preload: word i holds 32'h1000_0000 | i.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mem [1024];

    mem_arbiter_if bus ();

    mem_arbiter #(.MEM_SIZE(1024)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_mem_rdata = mem[bus.o_mem_addr];

    always @(posedge clk) begin
        if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    end

    typedef struct {
        bit          id;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req0_valid = 0;
        bus.i_req1_valid = 0;
        bus.i_req0_we    = 0;
        bus.i_req1_we    = 0;
        bus.i_req0_addr  = '0;
        bus.i_req1_addr  = '0;
        bus.i_req0_wdata = '0;
        bus.i_req1_wdata = '0;
    endtask

    task automatic set_req(bit id, bit v, bit we,
                           logic [9:0] a, logic [31:0] d);
        if (id) begin
            bus.i_req1_valid = v;
            bus.i_req1_we    = we;
            bus.i_req1_addr  = a;
            bus.i_req1_wdata = d;
        end else begin
            bus.i_req0_valid = v;
            bus.i_req0_we    = we;
            bus.i_req0_addr  = a;
            bus.i_req0_wdata = d;
        end
    endtask

    // Single-requester transaction; starts and ends just after a posedge in IDLE.
    task automatic txn(bit id, bit we, logic [9:0] a,
                       logic [31:0] d, logic [31:0] exp);
        bus.i_rsp0_ready = 1;
        bus.i_rsp1_ready = 1;
        set_req(id, 1, we, a, d);
        @(negedge clk);
        chk("acc_rdy0", 32'(bus.o_req0_ready), 32'(!id));
        chk("acc_rdy1", 32'(bus.o_req1_ready), 32'(id));
        tick();
        set_req(id, 0, 0, '0, '0);
        @(negedge clk);
        chk("access_we", 32'(bus.o_mem_we), 32'(we));
        chk("access_addr", 32'(bus.o_mem_addr), 32'(a));
        chk("access_busy", 32'(bus.o_busy), 1);
        chk("access_rv", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 0);
        tick();
        @(negedge clk);
        chk("resp_rv0", 32'(bus.o_rsp0_valid), 32'(!id));
        chk("resp_rv1", 32'(bus.o_rsp1_valid), 32'(id));
        chk("resp_rdata", id ? bus.o_rsp1_rdata : bus.o_rsp0_rdata, exp);
        chk("resp_other0", id ? bus.o_rsp0_rdata : bus.o_rsp1_rdata, 0);
        chk("resp_we", 32'(bus.o_mem_we), 0);
        tick();
        @(negedge clk);
        chk("back_idle", 32'(bus.o_busy), 0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit g;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
        idle_inputs();
        bus.i_rsp0_ready = 0;
        bus.i_rsp1_ready = 0;

        tbl[0] = '{0, 1, 10'h004, 32'h0000_00AA, 32'h1000_0004};
        tbl[1] = '{0, 0, 10'h004, 32'h0,         32'h0000_00AA};
        tbl[2] = '{1, 0, 10'h004, 32'h0,         32'h0000_00AA};
        tbl[3] = '{1, 1, 10'h010, 32'h0000_0002, 32'h1000_0010};
        tbl[4] = '{0, 1, 10'h010, 32'h0000_0001, 32'h0000_0002};
        tbl[5] = '{1, 0, 10'h010, 32'h0,         32'h0000_0001};
        tbl[6] = '{0, 0, 10'h000, 32'h0,         32'h1000_0000};
        tbl[7] = '{1, 0, 10'h200, 32'h0,         32'h1000_0200};

        rst = 1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_we", 32'(bus.o_mem_we), 0);
        chk("rst_addr", 32'(bus.o_mem_addr), 0);
        chk("rst_rv", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 0);
        chk("rst_rdy", 32'({bus.o_req1_ready, bus.o_req0_ready}), 0);
        tick();
        rst = 0;

        // Both requesters held valid: grants alternate 0,1,0,1.
        bus.i_rsp0_ready = 1;
        bus.i_rsp1_ready = 1;
        set_req(0, 1, 0, 10'h020, '0);
        set_req(1, 1, 0, 10'h021, '0);
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            @(negedge clk);
            chk("rr_rdy0", 32'(bus.o_req0_ready), 32'(!g));
            chk("rr_rdy1", 32'(bus.o_req1_ready), 32'(g));
            tick();
            tick();
            @(negedge clk);
            chk("rr_rv", 32'({bus.o_rsp1_valid, bus.o_rsp0_valid}),
                g ? 32'd2 : 32'd1);
            chk("rr_rdata", g ? bus.o_rsp1_rdata : bus.o_rsp0_rdata,
                g ? 32'h1000_0021 : 32'h1000_0020);
            tick();
        end
        idle_inputs();

        // Pointer is back at 0; lone req1 must still win immediately.
        txn(1, 0, 10'h021, '0, 32'h1000_0021);

        for (int i = 0; i < 8; i++)
            txn(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

        // Response back-pressure on requester 1 for five cycles.
        bus.i_rsp1_ready = 0;
        bus.i_rsp0_ready = 1;
        set_req(1, 1, 0, 10'h100, '0);
        @(negedge clk);
        chk("st_rdy1", 32'(bus.o_req1_ready), 1);
        tick();
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 0, 10'h101, '0);
        @(negedge clk);
        chk("st_acc_rdy0", 32'(bus.o_req0_ready), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("st_rv1", 32'(bus.o_rsp1_valid), 1);
            chk("st_rv0", 32'(bus.o_rsp0_valid), 0);
            chk("st_rdata", bus.o_rsp1_rdata, 32'h1000_0100);
            chk("st_rdy", 32'({bus.o_req1_ready, bus.o_req0_ready}), 0);
            chk("st_busy", 32'(bus.o_busy), 1);
            tick();
        end
        bus.i_rsp1_ready = 1;
        @(negedge clk);
        chk("st_rel_rv1", 32'(bus.o_rsp1_valid), 1);
        tick();
        @(negedge clk);
        chk("st_next_rdy0", 32'(bus.o_req0_ready), 1);
        tick();
        set_req(0, 0, 0, '0, '0);
        tick();
        @(negedge clk);
        chk("st_next_rv0", 32'(bus.o_rsp0_valid), 1);
        chk("st_next_rd", bus.o_rsp0_rdata, 32'h1000_0101);
        tick();

        // Reset lands during ACCESS of a store: nothing written, no response.
        set_req(0, 1, 1, 10'h3FF, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("ra_rdy0", 32'(bus.o_req0_ready), 1);
        tick();
        set_req(0, 0, 0, '0, '0);
        rst = 1;
        @(negedge clk);
        chk("ra_we", 32'(bus.o_mem_we), 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("ra_busy", 32'(bus.o_busy), 0);
        chk("ra_rv0", 32'(bus.o_rsp0_valid), 0);
        tick();
        @(negedge clk);
        chk("ra_rv0_b", 32'(bus.o_rsp0_valid), 0);
        tick();
        txn(0, 0, 10'h3FF, '0, 32'h1000_03FF);

        do_reset();
        txn(1, 0, 10'h004, '0, 32'h0000_00AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_SIZE, default 1024, data_memory depth in words.
REQ-002 Parameter: ADDR_W, default $clog2(MEM_SIZE) = 10, word-address width.
REQ-003 Parameter: DATA_W, default `DATA_WIDTH (32), data width.
REQ-004 i_clk  in  1  sole clock; all state updates on posedge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_req0_valid / i_req1_valid  in  1  requester N has an access pending.
REQ-007 o_req0_ready / o_req1_ready  out  1  arbiter accepts requester N's access this cycle.
REQ-008 i_req0_we / i_req1_we  in  1  1 = store, 0 = load.
REQ-009 i_req0_addr / i_req1_addr  in  ADDR_W  word address.
REQ-010 i_req0_wdata / i_req1_wdata  in  DATA_W  store data.
REQ-011 o_rsp0_valid / o_rsp1_valid  out  1  response for requester N is valid.
REQ-012 i_rsp0_ready / i_rsp1_ready  in  1  requester N consumes its response.
REQ-013 o_rsp0_rdata / o_rsp1_rdata  out  DATA_W  read data (load) or pre-write memory contents (store).
REQ-014 o_mem_we  out  1  to data_memory i_we.
REQ-015 o_mem_addr  out  ADDR_W  to data_memory i_addr.
REQ-016 o_mem_wdata  out  DATA_W  to data_memory i_data.
REQ-017 i_mem_rdata  in  DATA_W  from data_memory o_data (combinational read of o_mem_addr).
REQ-018 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-020 IDLE: if any valid, grant one requester, assert only its o_reqN_ready combinationally, latch its we/addr/wdata and grant id, go ACCESS; else stay IDLE.
REQ-021 Arbitration: both valid -> grant requester indicated by priority pointer; one valid -> grant it regardless of pointer.
REQ-022 Priority pointer SHALL switch to the non-granted requester on each completed response handshake (round-robin).
REQ-023 ACCESS (exactly one cycle): drive o_mem_addr/o_mem_wdata from latches, o_mem_we = latched we; capture i_mem_rdata into rdata register at the posedge; go RESP.
REQ-024 Store commits at the ACCESS→RESP posedge; rdata captured is the pre-write value.
REQ-025 RESP: assert o_rspN_valid for the granted id only, o_rspN_rdata = rdata register; hold until i_rspN_ready, then go IDLE.
REQ-026 Latency: accept in cycle T -> o_rspN_valid first high in T+2; back-to-back minimum 3 cycles per access.
REQ-027 o_reqN_ready SHALL be 0 outside IDLE; valid inputs outside IDLE are ignored (requester holds them).
REQ-028 o_mem_we SHALL be 0 in IDLE and RESP; o_mem_addr/o_mem_wdata hold latched values in all states.
REQ-029 Non-granted o_rspN_rdata SHALL read 0.
REQ-030 Address SHALL be used unmodified; no range check (ADDR_W covers MEM_SIZE exactly).
REQ-031 i_rspN_ready asserted while o_rspN_valid low SHALL have no effect.

Reset
REQ-032 On i_rst at posedge: state IDLE, pointer = 0, latches and rdata = 0, all o_reqN_ready/o_rspN_valid/o_busy = 0.
REQ-033 o_mem_we SHALL be forced 0 combinationally while i_rst is high, so a reset during ACCESS commits no store.
REQ-034 Reset mid-transaction drops the transaction; no response is issued for it.

Structure
REQ-035 FSM state encodings and DATA_WIDTH SHALL live in the shared defines header; no other constants shared.
REQ-036 One sub-module, rr_arb2: two requests + pointer in, one-hot grant out, purely combinational.
REQ-037 data_memory SHALL be instantiated outside mem_arbiter (at CPU top level).

Verification
REQ-038 Reset, req0 store addr 0x004 data 0x0000_00AA, rsp0_ready=1 -> o_mem_we high one cycle, rsp0 at T+2; then req0 load 0x004 -> rdata 0x0000_00AA.
REQ-039 Both valid same cycle after reset -> req0 granted first, req1 granted next IDLE; repeat -> alternates 0,1,0,1.
REQ-040 req1 only valid, pointer=0 -> req1 granted immediately.
REQ-041 rsp1_ready held low 5 cycles -> o_rsp1_valid and rdata stable, o_req*_ready stay 0, o_busy 1.
REQ-042 i_rst pulsed during ACCESS of store 0x3FF data 0xDEAD_BEEF -> o_mem_we 0, later load 0x3FF returns old value, no response issued.
REQ-043 Store 0x010 data 0x1 over existing 0x2 -> store response rdata 0x2, subsequent load 0x1.
